// File: rtl/pc_sequencer_pkg.sv
// Shared types for the fetch-stage program counter sequencer.
// Action codes 0-3 keep the values of the original PC action set.
package pc_sequencer_pkg;

  localparam int unsigned ACT_W = 3;

  typedef enum logic [ACT_W-1:0] {
    PC_NONE   = 3'd0,
    PC_INC    = 3'd1,
    PC_BRANCH = 3'd2,
    PC_JUMP   = 3'd3,
    PC_JREG   = 3'd4,
    PC_CALL   = 3'd5,
    PC_RET    = 3'd6,
    PC_ERET   = 3'd7
  } Pc_Action;

endpackage

// File: rtl/pc_return_stack.sv
// Circular return-address stack with a saturating depth counter.
// When full, a push overwrites the oldest entry so the newest DEPTH returns survive.
module pc_return_stack #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [ADDR_W-1:0] push_data_i,
  output logic [ADDR_W-1:0] top_o,
  output logic [CNT_W-1:0]  depth_o,
  output logic              empty_o
);

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  depth_q, depth_d;
  logic [PTR_W-1:0]  topIdx;

  // ptr_q always names the slot the next push writes; the top sits just below it
  assign topIdx  = ptr_q - PTR_W'(1);
  assign top_o   = mem_q[topIdx];
  assign depth_o = depth_q;
  assign empty_o = (depth_q == '0);

  always_comb begin
    ptr_d   = ptr_q;
    depth_d = depth_q;
    if (push_i) begin
      ptr_d = ptr_q + PTR_W'(1);
      if (depth_q != CNT_W'(DEPTH)) begin
        depth_d = depth_q + CNT_W'(1);
      end
    end else if (pop_i && !empty_o) begin
      ptr_d   = topIdx;
      depth_d = depth_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      depth_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      depth_q <= depth_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: trap/stall/action priority mux, target adders,
// EPC register and a return-address stack for CALL/RET.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned    ADDR_W    = 32,
  parameter int unsigned    OFFSET_W  = 16,
  parameter int unsigned    JUMP_W    = 26,
  parameter int unsigned    STEP      = 4,
  parameter logic [ADDR_W-1:0] RESET  = '0,
  parameter logic [ADDR_W-1:0] TRAP_VEC = 'h80,
  parameter int unsigned    RAS_DEPTH = 8,
  localparam int unsigned   SKIP      = $clog2(STEP),
  localparam int unsigned   CNT_W     = $clog2(RAS_DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall_i,
  input  logic                trap_i,
  input  Pc_Action            act_i,
  input  logic [OFFSET_W-1:0] offset_i,
  input  logic [JUMP_W-1:0]   jump_i,
  input  logic [ADDR_W-1:0]   jreg_i,
  output logic [ADDR_W-1:0]   addr_o,
  output logic [ADDR_W-1:0]   epc_o,
  output logic [CNT_W-1:0]    ras_depth_o,
  output logic                ras_miss_o
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] epc_q, epc_d;
  logic              miss_q, miss_d;

  logic [ADDR_W-1:0] incTarget, branchTarget, jumpTarget, jregTarget;
  logic [ADDR_W-1:0] rasTop;
  logic              rasPush, rasPop, rasEmpty;

  assign incTarget    = addr_q + ADDR_W'(STEP);
  assign branchTarget = addr_q + {{(ADDR_W-OFFSET_W-SKIP){offset_i[OFFSET_W-1]}}, offset_i, {SKIP{1'b0}}};
  assign jumpTarget   = {addr_q[ADDR_W-1:JUMP_W+SKIP], jump_i, {SKIP{1'b0}}};
  assign jregTarget   = jreg_i & ~ADDR_W'(STEP - 1);

  // Trap beats stall beats the action; a stalled cycle also clears the miss pulse
  always_comb begin
    addr_d  = addr_q;
    epc_d   = epc_q;
    miss_d  = 1'b0;
    rasPush = 1'b0;
    rasPop  = 1'b0;
    if (trap_i) begin
      epc_d  = addr_q;
      addr_d = TRAP_VEC;
    end else if (!stall_i) begin
      case (act_i)
        PC_NONE:   addr_d = addr_q;
        PC_INC:    addr_d = incTarget;
        PC_BRANCH: addr_d = branchTarget;
        PC_JUMP:   addr_d = jumpTarget;
        PC_JREG:   addr_d = jregTarget;
        PC_CALL: begin
          addr_d  = jumpTarget;
          rasPush = 1'b1;
        end
        PC_RET: begin
          if (rasEmpty) begin
            addr_d = jregTarget;
            miss_d = 1'b1;
          end else begin
            addr_d = rasTop;
            rasPop = 1'b1;
          end
        end
        PC_ERET:   addr_d = epc_q;
        default:   addr_d = addr_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= RESET;
      epc_q  <= '0;
      miss_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      epc_q  <= epc_d;
      miss_q <= miss_d;
    end
  end

  pc_return_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (rasPush),
    .pop_i       (rasPop),
    .push_data_i (incTarget),
    .top_o       (rasTop),
    .depth_o     (ras_depth_o),
    .empty_o     (rasEmpty)
  );

  assign addr_o     = addr_q;
  assign epc_o      = epc_q;
  assign ras_miss_o = miss_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized
// traffic compared against a queue-based reference model of the PC and return stack.
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        trap;
  Pc_Action    act;
  logic [15:0] offset;
  logic [25:0] jump;
  logic [31:0] jreg;
  logic [31:0] addr;
  logic [31:0] epc;
  logic [3:0]  rasDepth;
  logic        rasMiss;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mAddr;
  logic [31:0] mEpc;
  logic        mMiss;
  logic [31:0] mRas[$];

  pc_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall_i     (stall),
    .trap_i      (trap),
    .act_i       (act),
    .offset_i    (offset),
    .jump_i      (jump),
    .jreg_i      (jreg),
    .addr_o      (addr),
    .epc_o       (epc),
    .ras_depth_o (rasDepth),
    .ras_miss_o  (rasMiss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".addr"},  addr,                   mAddr);
    checkOutput({tag, ".epc"},   epc,                    mEpc);
    checkOutput({tag, ".depth"}, 32'(rasDepth),          32'(mRas.size()));
    checkOutput({tag, ".miss"},  32'(rasMiss),           32'(mMiss));
  endtask

  // One clock of stimulus; the model applies the same action at the edge
  task automatic applyStimulus(input logic st, input logic tr, input logic [2:0] a,
                               input logic [15:0] off, input logic [25:0] j,
                               input logic [31:0] jr, input string tag);
    logic [31:0] oldAddr;
    stall  = st;
    trap   = tr;
    act    = Pc_Action'(a);
    offset = off;
    jump   = j;
    jreg   = jr;
    @(posedge clk);
    oldAddr = mAddr;
    mMiss   = 1'b0;
    if (tr) begin
      mEpc  = oldAddr;
      mAddr = 32'h80;
    end else if (!st) begin
      case (a)
        3'd1: mAddr = oldAddr + 32'd4;
        3'd2: mAddr = oldAddr + 32'($signed(off)) * 4;
        3'd3: mAddr = (oldAddr & 32'hF000_0000) | (32'(j) * 4);
        3'd4: mAddr = jr & ~32'd3;
        3'd5: begin
          mRas.push_back(oldAddr + 32'd4);
          if (mRas.size() > 8) void'(mRas.pop_front());
          mAddr = (oldAddr & 32'hF000_0000) | (32'(j) * 4);
        end
        3'd6: begin
          if (mRas.size() == 0) begin
            mAddr = jr & ~32'd3;
            mMiss = 1'b1;
          end else begin
            mAddr = mRas.pop_back();
          end
        end
        3'd7: mAddr = mEpc;
        default: mAddr = oldAddr;
      endcase
    end
    #1;
    checkAll(tag);
  endtask

  task automatic doReset(input string tag);
    rst_n = 1'b0;
    #1;
    mAddr = 32'h0;
    mEpc  = 32'h0;
    mMiss = 1'b0;
    mRas.delete();
    checkAll(tag);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n  = 1'b0;
    stall  = 1'b0;
    trap   = 1'b0;
    act    = PC_NONE;
    offset = '0;
    jump   = '0;
    jreg   = '0;
    mAddr  = 32'h0;
    mEpc   = 32'h0;
    mMiss  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkAll("reset");
    rst_n = 1'b1;

    $display("[TB] reset mid-run, then INC x3");
    applyStimulus(0, 0, 3'd3, 16'h0, 26'h10, 32'h0, "jump40");
    checkOutput("at40", addr, 32'h40);
    doReset("midReset");
    checkOutput("rstImmediate", addr, 32'h0);
    applyStimulus(0, 0, 3'd1, 16'h0, 26'h0, 32'h0, "inc1");
    checkOutput("inc1Const", addr, 32'h4);
    applyStimulus(0, 0, 3'd1, 16'h0, 26'h0, 32'h0, "inc2");
    checkOutput("inc2Const", addr, 32'h8);
    applyStimulus(0, 0, 3'd1, 16'h0, 26'h0, 32'h0, "inc3");
    checkOutput("inc3Const", addr, 32'hC);

    $display("[TB] branch and wrap");
    applyStimulus(0, 0, 3'd4, 16'h0, 26'h0, 32'h100, "jreg100");
    applyStimulus(0, 0, 3'd2, 16'hFFFE, 26'h0, 32'h0, "branchNeg");
    checkOutput("branchNegConst", addr, 32'hF8);
    applyStimulus(0, 0, 3'd4, 16'h0, 26'h0, 32'hFFFF_FFFC, "jregTop");
    applyStimulus(0, 0, 3'd1, 16'h0, 26'h0, 32'h0, "incWrap");
    checkOutput("incWrapConst", addr, 32'h0);

    $display("[TB] jump and register jump");
    applyStimulus(0, 0, 3'd4, 16'h0, 26'h0, 32'h4000_0010, "jregHi");
    applyStimulus(0, 0, 3'd3, 16'h0, 26'h10, 32'h0, "jumpHi");
    checkOutput("jumpHiConst", addr, 32'h4000_0040);
    applyStimulus(0, 0, 3'd4, 16'h0, 26'h0, 32'h1237, "jregAlign");
    checkOutput("jregAlignConst", addr, 32'h1234);

    $display("[TB] return stack saturation and LIFO");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(0, 0, 3'd4, 16'h0, 26'h0, 32'((i + 1) * 16), "callSetup");
      applyStimulus(0, 0, 3'd5, 16'h0, 26'h0, 32'h0, "call");
    end
    checkOutput("depthSat", 32'(rasDepth), 32'd8);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 0, 3'd6, 16'h0, 26'h0, 32'h0, "ret");
      checkOutput("retConst", addr, 32'((9 - i) * 16 + 4));
    end
    applyStimulus(0, 0, 3'd6, 16'h0, 26'h0, 32'h500, "retEmpty");
    checkOutput("retEmptyAddr", addr, 32'h500);
    checkOutput("retEmptyMiss", 32'(rasMiss), 32'd1);
    applyStimulus(0, 0, 3'd0, 16'h0, 26'h0, 32'h0, "missClear");
    checkOutput("missClearConst", 32'(rasMiss), 32'd0);

    $display("[TB] trap over stall and call, then ERET");
    applyStimulus(0, 0, 3'd5, 16'h0, 26'h0, 32'h0, "preCall");
    applyStimulus(0, 0, 3'd4, 16'h0, 26'h0, 32'h30, "jreg30");
    applyStimulus(1, 1, 3'd5, 16'h0, 26'h0, 32'h0, "trap");
    checkOutput("trapAddr", addr, 32'h80);
    checkOutput("trapEpc", epc, 32'h30);
    checkOutput("trapDepth", 32'(rasDepth), 32'd1);
    applyStimulus(0, 0, 3'd7, 16'h0, 26'h0, 32'h0, "eret");
    checkOutput("eretConst", addr, 32'h30);

    $display("[TB] stall holds");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 3'd1, 16'h0, 26'h0, 32'h0, "stall");
      checkOutput("stallConst", addr, 32'h30);
    end
    applyStimulus(0, 0, 3'd1, 16'h0, 26'h0, 32'h0, "unstall");
    checkOutput("unstallConst", addr, 32'h34);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        doReset("randReset");
      end else begin
        applyStimulus(($urandom_range(0, 4) == 0), ($urandom_range(0, 15) == 0),
                      3'($urandom_range(0, 7)), 16'($urandom), 26'($urandom),
                      $urandom, "rand");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
